// File: rtl/decoded_block_buffer_pkg.sv
// Shared definitions for the decoded block buffer and its consumers.
// Entry layout puts the decoded word in the MSBs and the timestamp in the LSBs,
// matching the ram_block_wanted_N bus of the polynomial manager.
package decoded_block_buffer_pkg;

    localparam int DATA_W     = 17;
    localparam int TS_W       = 24;
    localparam int ENTRY_W    = DATA_W + TS_W;
    localparam int BLOCK_NB_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] decoded;
        logic [TS_W-1:0]   ts;
    } entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] decoded,
                                                      input logic [TS_W-1:0]   ts);
        entry_t e;
        e.decoded = decoded;
        e.ts      = ts;
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] entry_decoded(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1:TS_W];
    endfunction

    function automatic logic [TS_W-1:0] entry_ts(input logic [ENTRY_W-1:0] e);
        return e[TS_W-1:0];
    endfunction

endpackage

// File: rtl/decoded_block_buffer_block_ram_sdp.sv
// Simple dual-port RAM, 2^ADDR_WIDTH x WIDTH, one write port and one read port
// with a registered (1-cycle) output. No reset on the array or read register so
// that it maps onto embedded block RAM.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every cycle
//   rd_data  - read data, valid one cycle after rd_addr
module block_ram_sdp
    import decoded_block_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/decoded_block_buffer.sv
// Circular store of decoded words + timestamps for one sensor channel, serving
// numbered block requests (k = k-th most recent entry) to the polynomial search.
// Ports:
//   clk_72MHz           - system clock
//   reset               - synchronous, active-high reset
//   wr_valid            - one-cycle pulse, new decoded word present
//   wr_decoded_data     - decoded word
//   wr_ts               - timestamp of the word
//   lock                - freeze contents; writes are dropped and counted
//   clear               - one-cycle flush of all entries (dropped_count kept)
//   block_wanted_number - requested block, 0 = no request
//   ram_block_wanted    - {decoded, ts} of the requested block, 0 when not ready
//   ram_data_ready      - ram_block_wanted is valid for the current request
//   avl_blocks_nb       - number of valid stored entries
//   dropped_count       - saturating count of writes discarded while locked
module decoded_block_buffer
    import decoded_block_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clk_72MHz,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_decoded_data,
    input  logic [TS_W-1:0]       wr_ts,
    input  logic                  lock,
    input  logic                  clear,
    input  logic [BLOCK_NB_W-1:0] block_wanted_number,
    output logic [ENTRY_W-1:0]    ram_block_wanted,
    output logic                  ram_data_ready,
    output logic [BLOCK_NB_W-1:0] avl_blocks_nb,
    output logic [7:0]            dropped_count
);

    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [BLOCK_NB_W-1:0] AVL_MAX = BLOCK_NB_W'(DEPTH - 1);
    // Request stage + RAM stage carry qualification bits; the output register
    // is the last stage, so the valid shift register is one shorter than the latency.
    localparam int                    STAGES  = READ_LATENCY - 1;

    logic [ADDR_WIDTH-1:0] head;
    logic [BLOCK_NB_W-1:0] req_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ENTRY_W-1:0]    rd_data;
    logic [STAGES-1:0]     vld_pipe;
    logic [STAGES-1:0]     ok_pipe;
    logic                  wr_accept;
    logic                  wr_dropped;
    logic                  req_ok;
    logic                  disturb;
    logic                  out_ok;

    assign wr_accept  = wr_valid & ~lock & ~clear;
    assign wr_dropped = wr_valid &  lock & ~clear;
    assign req_ok     = (block_wanted_number != '0) && (block_wanted_number <= avl_blocks_nb);
    // Anything that can change what block k refers to, or k itself.
    assign disturb    = wr_accept | clear | (block_wanted_number != req_q);
    assign out_ok     = vld_pipe[STAGES-1] & ok_pipe[STAGES-1] & ~disturb;

    block_ram_sdp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (ENTRY_W)
    ) u_ram (
        .clk     (clk_72MHz),
        .wr_en   (wr_accept),
        .wr_addr (head),
        .wr_data (pack_entry(wr_decoded_data, wr_ts)),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Write pointer, fill level and drop counter.
    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            head          <= '0;
            avl_blocks_nb <= '0;
            dropped_count <= '0;
        end else begin
            if (clear) begin
                head          <= '0;
                avl_blocks_nb <= '0;
            end else if (wr_accept) begin
                head <= head + 1'b1;
                if (avl_blocks_nb != AVL_MAX)
                    avl_blocks_nb <= avl_blocks_nb + 1'b1;
            end
            if (wr_dropped && dropped_count != 8'hFF)
                dropped_count <= dropped_count + 1'b1;
        end
    end

    // Request / ready pipeline. A new request number is captured with the
    // current head, so its first stage is already usable. A write or clear
    // makes the address computed this cycle stale, so that stage is discarded
    // and qualification restarts one cycle later.
    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            req_q            <= '0;
            rd_addr          <= '0;
            vld_pipe         <= '0;
            ok_pipe          <= '0;
            ram_data_ready   <= 1'b0;
            ram_block_wanted <= '0;
        end else begin
            req_q       <= block_wanted_number;
            rd_addr     <= head - ADDR_WIDTH'(block_wanted_number);
            vld_pipe[0] <= ~(wr_accept | clear);
            ok_pipe[0]  <= req_ok;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~disturb;
                ok_pipe[i]  <= ok_pipe[i-1];
            end
            ram_data_ready   <= out_ok;
            ram_block_wanted <= out_ok ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_decoded_block_buffer.sv
module tb_decoded_block_buffer;
    import decoded_block_buffer_pkg::*;

    logic                  clk_72MHz = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_valid = 1'b0;
    logic [DATA_W-1:0]     wr_decoded_data = '0;
    logic [TS_W-1:0]       wr_ts = '0;
    logic                  lock = 1'b0;
    logic                  clear = 1'b0;
    logic [BLOCK_NB_W-1:0] block_wanted_number = '0;
    logic [ENTRY_W-1:0]    ram_block_wanted;
    logic                  ram_data_ready;
    logic [BLOCK_NB_W-1:0] avl_blocks_nb;
    logic [7:0]            dropped_count;

    always #5 clk_72MHz = ~clk_72MHz;

    decoded_block_buffer #(.ADDR_WIDTH(8), .READ_LATENCY(3)) dut (
        .clk_72MHz           (clk_72MHz),
        .reset               (reset),
        .wr_valid            (wr_valid),
        .wr_decoded_data     (wr_decoded_data),
        .wr_ts               (wr_ts),
        .lock                (lock),
        .clear               (clear),
        .block_wanted_number (block_wanted_number),
        .ram_block_wanted    (ram_block_wanted),
        .ram_data_ready      (ram_data_ready),
        .avl_blocks_nb       (avl_blocks_nb),
        .dropped_count       (dropped_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: list of stored words, most recent first, plus the
    // request numbers and "nothing moved" flags seen at the last three edges.
    logic [40:0] q[$];
    int          m_dropped = 0;
    logic [7:0]  hk[3] = '{default: 8'd0};
    bit          hc[3] = '{default: 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_check();
        bit          exp_rdy;
        logic [40:0] exp_data;
        int          k;
        k        = int'(hk[0]);
        exp_rdy  = hc[0] && hc[1] && hc[2] && hk[0] == hk[1] && hk[1] == hk[2]
                   && k >= 1 && k <= q.size();
        exp_data = '0;
        if (exp_rdy) exp_data = q[k-1];
        chk("model_ready",   64'(ram_data_ready),   64'(exp_rdy));
        chk("model_data",    64'(ram_block_wanted), 64'(exp_data));
        chk("model_avl",     64'(avl_blocks_nb),    64'(q.size()));
        chk("model_dropped", 64'(dropped_count),    64'(m_dropped));
    endtask

    // One clock edge: update the model with the inputs the DUT samples, then
    // compare just after the edge.
    task automatic tick();
        bit clean;
        @(posedge clk_72MHz);
        clean = 1'b1;
        if (reset) begin
            q.delete();
            m_dropped = 0;
            clean = 1'b0;
        end else if (clear) begin
            q.delete();
            clean = 1'b0;
        end else if (wr_valid && !lock) begin
            q.push_front({wr_decoded_data, wr_ts});
            if (q.size() > 255) void'(q.pop_back());
            clean = 1'b0;
        end else if (wr_valid && lock && m_dropped < 255) begin
            m_dropped++;
        end
        hk[2] = hk[1]; hk[1] = hk[0]; hk[0] = block_wanted_number;
        hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = clean;
        #1;
        model_check();
    endtask

    task automatic write_word(input logic [16:0] d, input logic [23:0] ts);
        wr_valid = 1'b1;
        wr_decoded_data = d;
        wr_ts = ts;
        tick();
        wr_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  k;
        int          cycles;
        logic        rdy;
        logic [40:0] data;
    } vec_t;

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'd1, 3,  1'b1, {17'h00033, 24'h000300}};
        vecs[1] = '{8'd3, 2,  1'b0, 41'd0};
        vecs[2] = '{8'd3, 1,  1'b1, {17'h00011, 24'h000100}};
        vecs[3] = '{8'd4, 20, 1'b0, 41'd0};
        vecs[4] = '{8'd0, 20, 1'b0, 41'd0};
        vecs[5] = '{8'd2, 3,  1'b1, {17'h00022, 24'h000200}};

        // Reset state
        reset = 1'b1;
        tick(); tick();
        chk("rst_ready",   64'(ram_data_ready),   64'd0);
        chk("rst_data",    64'(ram_block_wanted), 64'd0);
        chk("rst_avl",     64'(avl_blocks_nb),    64'd0);
        chk("rst_dropped", 64'(dropped_count),    64'd0);
        reset = 1'b0;
        tick();

        // Three words, then table-driven requests
        write_word(17'h00011, 24'h000100);
        write_word(17'h00022, 24'h000200);
        write_word(17'h00033, 24'h000300);
        chk("avl3", 64'(avl_blocks_nb), 64'd3);
        foreach (vecs[i]) begin
            block_wanted_number = vecs[i].k;
            repeat (vecs[i].cycles) tick();
            chk($sformatf("vec%0d_ready", i), 64'(ram_data_ready),   64'(vecs[i].rdy));
            chk($sformatf("vec%0d_data", i),  64'(ram_block_wanted), 64'(vecs[i].data));
        end

        // Write while request 2 is ready: drop next cycle, back 3 cycles later
        write_word(17'h00044, 24'h000400);
        chk("wr_drop_ready", 64'(ram_data_ready), 64'd0);
        tick(); tick();
        chk("wr_still_low", 64'(ram_data_ready), 64'd0);
        tick();
        chk("wr_rise_ready", 64'(ram_data_ready),   64'd1);
        chk("wr_rise_data",  64'(ram_block_wanted), 64'({17'h00033, 24'h000300}));

        // Locked writes: dropped and counted, ready unaffected by the lock edge
        lock = 1'b1;
        tick();
        repeat (5) write_word(17'h1FFFF, 24'hFFFFFF);
        chk("lock_avl",     64'(avl_blocks_nb), 64'd4);
        chk("lock_dropped", 64'(dropped_count), 64'd5);
        chk("lock_ready",   64'(ram_data_ready), 64'd1);
        repeat (295) write_word(17'h0AAAA, 24'h555555);
        chk("lock_sat", 64'(dropped_count), 64'd255);
        lock = 1'b0;
        tick();
        chk("unlock_ready", 64'(ram_data_ready), 64'd1);

        // Pointer wrap: 260 words after a clear
        clear = 1'b1; tick(); clear = 1'b0;
        block_wanted_number = 8'd1;
        for (int i = 1; i <= 260; i++) write_word(17'(i), 24'(i * 256));
        repeat (3) tick();
        chk("wrap_avl",     64'(avl_blocks_nb),    64'd255);
        chk("wrap_k1_rdy",  64'(ram_data_ready),   64'd1);
        chk("wrap_k1_data", 64'(ram_block_wanted), 64'({17'd260, 24'(260 * 256)}));
        block_wanted_number = 8'd255;
        repeat (3) tick();
        chk("wrap_k255_data", 64'(ram_block_wanted), 64'({17'd6, 24'(6 * 256)}));

        // clear beats a simultaneous write
        clear = 1'b1; wr_valid = 1'b1; wr_decoded_data = 17'h12345; wr_ts = 24'hABCDEF;
        tick();
        clear = 1'b0; wr_valid = 1'b0;
        chk("clr_avl",   64'(avl_blocks_nb),  64'd0);
        chk("clr_ready", 64'(ram_data_ready), 64'd0);
        repeat (3) tick();
        chk("clr_ready_hold", 64'(ram_data_ready), 64'd0);
        chk("clr_dropped",    64'(dropped_count),  64'd255);

        // Reset during an active request
        write_word(17'h00077, 24'h000777);
        block_wanted_number = 8'd1;
        repeat (3) tick();
        chk("pre_rst_ready", 64'(ram_data_ready), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", 64'(ram_data_ready),   64'd0);
        chk("mid_rst_data",  64'(ram_block_wanted), 64'd0);
        chk("mid_rst_avl",   64'(avl_blocks_nb),    64'd0);
        chk("mid_rst_drop",  64'(dropped_count),    64'd0);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_valid        = ($urandom_range(0, 5) == 0);
            wr_decoded_data = 17'($urandom);
            wr_ts           = 24'($urandom);
            if ($urandom_range(0, 19) == 0) lock = ~lock;
            clear = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0)
                block_wanted_number = 8'($urandom_range(0, (q.size() + 2 > 255) ? 255 : q.size() + 2));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decoded_block_buffer.md
Name: decoded_block_buffer

Overview:
- Storage side of the block-fetch interface used by the polynomial search logic. One instance per sensor channel.
- Accepts decoded words with timestamps from the decoder and stores them in a circular buffer.
- Reports the number of available blocks and serves numbered block requests with a registered data word plus a stable data-ready flag.
- Outputs connect directly to ram_block_wanted_N / ram_data_ready_N / avl_blocks_nb_N of the polynomial manager.

Parameters:
- ADDR_WIDTH, 8, RAM address width. Depth is 2^ADDR_WIDTH; available count saturates at 2^ADDR_WIDTH-1.
- READ_LATENCY, 3, cycles from a stable valid request to ram_data_ready high. Fixed by the pipeline; the parameter is for documentation and checking only.

Ports:
- clk_72MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  single-cycle pulse: new decoded word present
- wr_decoded_data  in  17  decoded polynomial bit-stream word
- wr_ts  in  24  timestamp of the word
- lock  in  1  freeze buffer contents while the consumer searches
- clear  in  1  single-cycle flush of all entries
- block_wanted_number  in  8  requested block. 0 = no request; k = k-th most recent entry
- ram_block_wanted  out  41  {decoded[16:0], ts[23:0]} of the requested block
- ram_data_ready  out  1  ram_block_wanted is valid for the current request
- avl_blocks_nb  out  8  number of valid stored entries
- dropped_count  out  8  saturating count of writes discarded while locked

Behaviour:
- Reset (synchronous, active-high):
  - head pointer = 0, avl_blocks_nb = 0, dropped_count = 0.
  - ram_block_wanted = 0, ram_data_ready = 0.
  - Request pipeline is cleared. RAM contents are don't-care.
- Write, accepted when wr_valid=1, lock=0, clear=0:
  - RAM[head] <= {wr_decoded_data, wr_ts}; head <= head+1, wrapping modulo 2^ADDR_WIDTH.
  - avl_blocks_nb <= min(avl+1, 2^ADDR_WIDTH-1). When full, the oldest entry is overwritten.
- Write while lock=1: discarded. dropped_count increments and saturates at 255. Contents and avl are unchanged.
- clear=1: head and avl reset to 0, ram_data_ready cleared next cycle, dropped_count is preserved. clear beats a simultaneous write; clear works regardless of lock.
- Block addressing: block k maps to address (head - k) mod 2^ADDR_WIDTH.
  - A request is valid iff 1 <= k <= avl_blocks_nb.
- Read pipeline:
  - Stage 1: register the request and compute the address.
  - Stage 2: synchronous RAM read.
  - Stage 3: register the output.
- ram_data_ready rules:
  - Rises exactly READ_LATENCY cycles after block_wanted_number becomes a valid value and then stays unchanged.
  - Stays high while the number, avl and head stay unchanged.
  - Falls on the cycle after block_wanted_number changes, any write is accepted, or clear occurs. Pipeline qualification restarts from that point.
- Invalid request (0 or > avl): ram_data_ready=0, ram_block_wanted=0 after the same latency. The consumer may hold the number indefinitely.
- Request changing every cycle: ram_data_ready never asserts.
- Request unchanged across a lock edge: no effect on ram_data_ready.
- avl_blocks_nb is registered and updates one cycle after the accepted write or clear.
- Reset mid-request: all outputs return to reset values on the next edge.

Decomposition:
- Shared package, also usable by the polynomial logic:
  - DATA_W=17, TS_W=24, ENTRY_W=41, BLOCK_NB_W=8.
  - Entry pack/unpack helpers (decoded in the MSBs).
- One sub-module: block_ram_sdp, a simple dual-port RAM of 2^ADDR_WIDTH x ENTRY_W.
  - One write port, one registered read port with 1-cycle latency.
  - Inferable as embedded block RAM.
- Top-level RTL holds the pointers, counters and request/ready pipeline.

Test Plan:
- Write 3 words (D=0x00011/TS=0x000100, 0x00022/0x000200, 0x00033/0x000300), hold request 1 → avl=3; after 3 cycles ram_data_ready=1, ram_block_wanted={0x00033,0x000300}. Request 3 → {0x00011,0x000100}.
- Hold request 4 or request 0 with avl=3 → ram_data_ready stays 0 for 20 cycles, data=0.
- Hold request 2 with ready high, then accept a write → ready falls the next cycle and rises 3 cycles later with the entry previously numbered 1.
- Set lock=1, issue 5 writes → avl unchanged, dropped_count=5; 300 locked writes → dropped_count=255.
- Write 260 words unlocked → avl=255; request 1 returns word 260, request 255 returns word 6, exercising pointer wrap.
- Pulse clear together with wr_valid → avl=0, ready=0, write ignored. Assert reset during an active request → all outputs zero on the next edge.
